vga_sync_gen: RTL and testbench

//  Generates VGA 640x480@60 raster timing from the pixel clock.

---
 rtl/vga_sync_gen.sv | 118 +++++++++++
 tb/tb_vga_sync_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 raster timing; registered outputs decoded from next counters (zero skew to pix_x/pix_y).
// Free-running source, no backpressure; define PIX_DIV2_EN to tick every other clk (50 MHz board clock).
module vga_sync_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0,
    parameter int CW        = 11
) (
    input  logic          clk,
    input  logic          reset,
    output logic          h_sinc,
    output logic          v_sinc,
    output logic          video_on,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          line_start,
    output logic          frame_start,
    output logic          pix_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
    localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
    localparam logic [CW-1:0] HS_FIRST = CW'(H_VISIBLE + H_FRONT);
    localparam logic [CW-1:0] HS_LAST  = CW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(V_VISIBLE + V_FRONT);
    localparam logic [CW-1:0] VS_LAST  = CW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic          tick;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          h_sinc_q, h_sinc_d;
    logic          v_sinc_q, v_sinc_d;
    logic          video_on_q, video_on_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic          pix_tick_q, pix_tick_d;

`ifdef PIX_DIV2_EN
    logic phase_q, phase_d;

    // Phase 0 is the tick, so the first edge after reset release advances.
    assign phase_d = ~phase_q;
    assign tick    = ~phase_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + CW'(1);
            end else begin
                x_d = x_q + CW'(1);
            end
        end

        h_sinc_d      = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
        v_sinc_d      = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
        video_on_d    = (x_d < H_VIS) && (y_d < V_VIS);
        line_start_d  = tick && (x_d == '0);
        frame_start_d = tick && (x_d == '0) && (y_d == '0);
        pix_tick_d    = tick;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q           <= '0;
            y_q           <= '0;
            h_sinc_q      <= ~SYNC_POL;
            v_sinc_q      <= ~SYNC_POL;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            pix_tick_q    <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            h_sinc_q      <= h_sinc_d;
            v_sinc_q      <= v_sinc_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            pix_tick_q    <= pix_tick_d;
        end
    end

    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign h_sinc      = h_sinc_q;
    assign v_sinc      = v_sinc_q;
    assign video_on    = video_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign pix_tick    = pix_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a shrunken raster so whole frames fit; reference is a linear pixel index.
// Random run lengths and random mid-frame resets; also checks per-frame window counts.
module tb_vga_sync_gen;

    localparam int HV = 20;
    localparam int HF = 3;
    localparam int HS = 5;
    localparam int HB = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VV = 12;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam bit POL = 1'b0;
    localparam int CW = 11;
`ifdef PIX_DIV2_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          h_sinc, v_sinc, video_on;
    logic [CW-1:0] pix_x, pix_y;
    logic          line_start, frame_start, pix_tick;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: linear position in the frame plus tick bookkeeping.
    int pos;
    bit started, ticked, ph;
    int cnt_vid, cnt_hs, cnt_vs, cnt_ls, cnt_fs;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(POL), .CW(CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .h_sinc     (h_sinc),
        .v_sinc     (v_sinc),
        .video_on   (video_on),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .line_start (line_start),
        .frame_start(frame_start),
        .pix_tick   (pix_tick)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int x, y;
        bit e_vid, e_hs, e_vs;
        x     = pos % HT;
        y     = pos / HT;
        e_vid = started && (x < HV) && (y < VV);
        e_hs  = (x >= HV + HF && x < HV + HF + HS) ? POL : !POL;
        e_vs  = (y >= VV + VF && y < VV + VF + VS) ? POL : !POL;
        chk("pix_x", 32'(pix_x), 32'(x));
        chk("pix_y", 32'(pix_y), 32'(y));
        chk("video_on", 32'(video_on), 32'(e_vid));
        chk("h_sinc", 32'(h_sinc), 32'(e_hs));
        chk("v_sinc", 32'(v_sinc), 32'(e_vs));
        chk("line_start", 32'(line_start), 32'(ticked && x == 0));
        chk("frame_start", 32'(frame_start), 32'(ticked && pos == 0));
        chk("pix_tick", 32'(pix_tick), 32'(ticked));
    endtask

    task automatic model_edge();
        if (!reset) begin
            if (DIV == 1 || !ph) begin
                pos     = (pos + 1) % FT;
                started = 1'b1;
                ticked  = 1'b1;
            end else begin
                ticked = 1'b0;
            end
            if (DIV == 2) ph = !ph;
        end
    endtask

    task automatic model_reset();
        pos     = 0;
        started = 1'b0;
        ticked  = 1'b0;
        ph      = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_outputs();
            cnt_vid += int'(video_on);
            cnt_hs  += int'(h_sinc == POL);
            cnt_vs  += int'(v_sinc == POL);
            cnt_ls  += int'(line_start);
            cnt_fs  += int'(frame_start);
        end
    endtask

    // Asserted between edges: outputs must take reset values with no clock edge.
    task automatic apply_reset(input int hold_edges);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        run(hold_edges);
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        model_reset();
        #3;
        check_outputs();
        run(2);
        @(negedge clk);
        #1;
        reset = 1'b0;

        // One full frame window from release: every position visited once.
        cnt_vid = 0; cnt_hs = 0; cnt_vs = 0; cnt_ls = 0; cnt_fs = 0;
        run(1);
        chk("release_x", 32'(pix_x), 32'd1);
        chk("release_y", 32'(pix_y), 32'd0);
        chk("release_video_on", 32'(video_on), 32'd1);
        run(FT * DIV - 1);
        chk("frame_video_cnt", 32'(cnt_vid), 32'(HV * VV * DIV));
        chk("frame_hsync_cnt", 32'(cnt_hs), 32'(HS * VT * DIV));
        chk("frame_vsync_cnt", 32'(cnt_vs), 32'(VS * HT * DIV));
        chk("frame_line_starts", 32'(cnt_ls), 32'(VT));
        chk("frame_frame_starts", 32'(cnt_fs), 32'd1);

        run(int'($urandom_range(HT, FT * DIV)));

        for (int k = 0; k < 4; k++) begin
            run(int'($urandom_range(HT, FT * DIV)));
            apply_reset(int'($urandom_range(0, 2)));
            run(1);
            chk("rerelease_x", 32'(pix_x), 32'd1);
            chk("rerelease_y", 32'(pix_y), 32'd0);
        end

        run(FT * DIV + 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
